// File: rtl/fruit_tpl_pkg.sv
// fruit_tpl_pkg
// Shared constants and types for the fruit template path. The ROM wrappers,
// the matcher and the live-capture writer all agree on the template geometry
// declared here.
// Contents:
//   TPL_ADDR_W, TPL_DATA_W  template memory address / byte width
//   TPL_COLS, TPL_ROWS      template geometry (row-major, addr = row*COLS+col)
//   CNT_W                   width of the pixel / line position counters
//   tpl_state_t             capture FSM states
package fruit_tpl_pkg;

  localparam int TPL_ADDR_W = 11;
  localparam int TPL_DATA_W = 8;
  localparam int TPL_COLS   = 64;
  localparam int TPL_ROWS   = 32;
  localparam int CNT_W      = 12;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAP,
    DONE
  } tpl_state_t;

endpackage

// File: rtl/fruit_tpl_roi_sel.sv
// fruit_tpl_roi_sel
// Tracks the pixel position within the frame and flags the pixels that fall
// on the decimation grid inside the region of interest.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   frame_vs     frame sync (rising edge starts a frame)
//   pix_de       pixel valid
//   vs_rise      frame-start strobe (combinational, one cycle)
//   sample       current pixel is a template sample (combinational)
//   col, row     template coordinates of the current sample
module fruit_tpl_roi_sel #(
  parameter int TPL_COLS = fruit_tpl_pkg::TPL_COLS,
  parameter int TPL_ROWS = fruit_tpl_pkg::TPL_ROWS,
  parameter int X_START  = 288,
  parameter int Y_START  = 176,
  parameter int STEP     = 2,
  parameter int COL_W    = (TPL_COLS > 1) ? $clog2(TPL_COLS) : 1,
  parameter int ROW_W    = (TPL_ROWS > 1) ? $clog2(TPL_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_vs,
  input  logic             pix_de,
  output logic             vs_rise,
  output logic             sample,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row
);
  import fruit_tpl_pkg::*;

  localparam int PH_W = (STEP > 1) ? $clog2(STEP) : 1;

  // One extra bit so the ROI end bound can never alias into the counter range.
  typedef logic [CNT_W:0] cmp_t;
  localparam cmp_t X_LO = cmp_t'(X_START);
  localparam cmp_t X_HI = cmp_t'(X_START + TPL_COLS * STEP);
  localparam cmp_t Y_LO = cmp_t'(Y_START);
  localparam cmp_t Y_HI = cmp_t'(Y_START + TPL_ROWS * STEP);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(STEP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_d;
  logic             de_d;
  logic             de_fall;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic [PH_W-1:0]  x_ph;
  logic [PH_W-1:0]  y_ph;
  logic             x_in;
  logic             y_in;

  assign vs_rise = frame_vs & ~vs_d;
  assign de_fall = ~pix_de & de_d;
  assign x_in    = (cmp_t'(x_cnt) >= X_LO) && (cmp_t'(x_cnt) < X_HI);
  assign y_in    = (cmp_t'(y_cnt) >= Y_LO) && (cmp_t'(y_cnt) < Y_HI);
  assign sample  = pix_de && x_in && y_in && (x_ph == '0) && (y_ph == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      vs_d <= frame_vs;
      de_d <= pix_de;
    end
  end

  // Horizontal position. The x phase stays at 0 until the ROI is entered, so
  // the first ROI pixel of every line is always on the grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      x_ph  <= '0;
      col   <= '0;
    end else if (de_fall) begin
      x_cnt <= '0;
      x_ph  <= '0;
      col   <= '0;
    end else if (pix_de) begin
      if (x_cnt != CNT_MAX) x_cnt <= x_cnt + CNT_W'(1);
      if (x_in) x_ph <= (x_ph == PH_LAST) ? '0 : x_ph + PH_W'(1);
      if (sample) col <= col + COL_W'(1);
    end
  end

  // Vertical position, advanced at the end of each line. A template row is
  // finished when a line on the y grid inside the ROI ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt <= '0;
      y_ph  <= '0;
      row   <= '0;
    end else if (vs_rise) begin
      y_cnt <= '0;
      y_ph  <= '0;
      row   <= '0;
    end else if (de_fall) begin
      if (y_cnt != CNT_MAX) y_cnt <= y_cnt + CNT_W'(1);
      if (y_in) begin
        y_ph <= (y_ph == PH_LAST) ? '0 : y_ph + PH_W'(1);
        if (y_ph == '0) row <= row + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/fruit_tpl_writer.sv
// fruit_tpl_writer
// Captures a live fruit template from the feature byte stream: on request it
// waits for a frame start, decimates the ROI and writes the template into the
// template RAM with the same row-major layout as the factory ROMs.
// Ports:
//   clk, rst_n          pixel / RAM clock, asynchronous active-low reset
//   cap_start           single-cycle capture request
//   frame_vs, pix_de    frame sync and pixel valid
//   pix_data            feature byte
//   cap_busy            capture in progress
//   cap_done, cap_err   completion / abort pulses
//   ram_wr_en/addr/data template RAM write port (registered)
//   tpl_cksum           16-bit sum of the written bytes (FRUIT_TPL_CKSUM_EN only)
// Optional build macro: FRUIT_TPL_CKSUM_EN adds the tpl_cksum output.
module fruit_tpl_writer #(
  parameter int ADDR_WIDTH = fruit_tpl_pkg::TPL_ADDR_W,
  parameter int DATA_WIDTH = fruit_tpl_pkg::TPL_DATA_W,
  parameter int TPL_COLS   = fruit_tpl_pkg::TPL_COLS,
  parameter int TPL_ROWS   = fruit_tpl_pkg::TPL_ROWS,
  parameter int X_START    = 288,
  parameter int Y_START    = 176,
  parameter int STEP       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_start,
  input  logic                  frame_vs,
  input  logic                  pix_de,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic                  cap_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data
`ifdef FRUIT_TPL_CKSUM_EN
  ,
  output logic [15:0]           tpl_cksum
`endif
);
  import fruit_tpl_pkg::*;

  localparam int COL_W = (TPL_COLS > 1) ? $clog2(TPL_COLS) : 1;
  localparam int ROW_W = (TPL_ROWS > 1) ? $clog2(TPL_ROWS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  tpl_state_t            state;
  logic                  vs_rise;
  logic                  sample;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_fire;

  fruit_tpl_roi_sel #(
    .TPL_COLS (TPL_COLS),
    .TPL_ROWS (TPL_ROWS),
    .X_START  (X_START),
    .Y_START  (Y_START),
    .STEP     (STEP),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_roi_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_vs (frame_vs),
    .pix_de   (pix_de),
    .vs_rise  (vs_rise),
    .sample   (sample),
    .col      (col),
    .row      (row)
  );

  assign addr = ADDR_WIDTH'(int'(row) * TPL_COLS + int'(col));

  // A frame start during capture aborts, so it takes priority over a sample.
  assign wr_fire = (state == CAP) && !vs_rise && sample;

  // Capture FSM with registered status and RAM write port. cap_start is only
  // looked at in IDLE, which also swallows a frame start arriving with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_busy    <= 1'b0;
      cap_done    <= 1'b0;
      cap_err     <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      cap_done  <= 1'b0;
      cap_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cap_start) begin
            state    <= ARM;
            cap_busy <= 1'b1;
          end
        end
        ARM: begin
          if (vs_rise) state <= CAP;
        end
        CAP: begin
          if (vs_rise) begin
            state    <= IDLE;
            cap_err  <= 1'b1;
            cap_busy <= 1'b0;
          end else if (wr_fire) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= addr;
            ram_wr_data <= pix_data;
            if (addr == LAST_ADDR) begin
              state    <= DONE;
              cap_done <= 1'b1;
              cap_busy <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FRUIT_TPL_CKSUM_EN
  // Running sum of written bytes; it holds after completion until the next
  // accepted request clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpl_cksum <= '0;
    end else if ((state == IDLE) && cap_start) begin
      tpl_cksum <= '0;
    end else if (wr_fire) begin
      tpl_cksum <= tpl_cksum + 16'(pix_data);
    end
  end
`endif

endmodule

// File: tb/tb_fruit_tpl_writer.sv
// tb_fruit_tpl_writer
// Self-checking bench for fruit_tpl_writer on a small 16-pixel-wide frame
// with a 4x2 template. A behavioural model derives the expected RAM writes
// and status pulses from pixel coordinates; a negedge process compares the
// DUT against it every cycle. Define FRUIT_TPL_CKSUM_EN to also cover
// tpl_cksum.
module tb_fruit_tpl_writer;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TC = 4;
  localparam int TR = 2;
  localparam int XS = 2;
  localparam int YS = 1;
  localparam int ST = 2;
  localparam int FW = 16;
  localparam int NW = TC * TR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_start = 1'b0;
  logic          frame_vs = 1'b0;
  logic          pix_de = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          cap_busy;
  logic          cap_done;
  logic          cap_err;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
`ifdef FRUIT_TPL_CKSUM_EN
  logic [15:0]   tpl_cksum;
`endif

  fruit_tpl_writer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TPL_COLS   (TC),
    .TPL_ROWS   (TR),
    .X_START    (XS),
    .Y_START    (YS),
    .STEP       (ST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_start   (cap_start),
    .frame_vs    (frame_vs),
    .pix_de      (pix_de),
    .pix_data    (pix_data),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done),
    .cap_err     (cap_err),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data)
`ifdef FRUIT_TPL_CKSUM_EN
    ,
    .tpl_cksum   (tpl_cksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: 0 = idle, 1 = waiting for a frame start, 2 = capturing.
  int m_mode = 0;
  bit m_prev_vs = 1'b0;
  int m_next = 0;

  // Expected outputs after the latest clock edge (exp_*) and after the next
  // one (pend_*).
  bit pend_wr = 0, pend_done = 0, pend_err = 0, pend_busy = 0;
  int pend_addr = 0, pend_data = 0, pend_sum = 0;
  bit exp_wr = 0, exp_done = 0, exp_err = 0, exp_busy = 0;
  int exp_addr = 0, exp_data = 0, exp_sum = 0;

  bit cmp_en = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int wr_addr_log[$];
  int wr_data_log[$];

  int golden[8] = '{8'h12, 8'h14, 8'h16, 8'h18, 8'h32, 8'h34, 8'h36, 8'h38};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit is_sample(input int x, input int y);
    return (x >= XS) && (x < XS + TC * ST) && ((x - XS) % ST == 0) &&
           (y >= YS) && (y < YS + TR * ST) && ((y - YS) % ST == 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev_vs = 0; m_next = 0;
    pend_wr = 0; pend_done = 0; pend_err = 0; pend_busy = 0;
    pend_addr = 0; pend_data = 0; pend_sum = 0;
    exp_wr = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
    exp_addr = 0; exp_data = 0; exp_sum = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit vs, input bit de,
                            input int data, input int x, input int y);
    bit vs_rise;
    exp_wr = pend_wr; exp_done = pend_done; exp_err = pend_err; exp_busy = pend_busy;
    exp_addr = pend_addr; exp_data = pend_data; exp_sum = pend_sum;
    if (!r) begin
      model_reset();
      return;
    end
    vs_rise = vs && !m_prev_vs;
    m_prev_vs = vs;
    pend_wr = 0; pend_done = 0; pend_err = 0;
    case (m_mode)
      0: if (s) begin
           m_mode = 1; pend_busy = 1; pend_sum = 0; m_next = 0;
         end
      1: if (vs_rise) m_mode = 2;
      default: begin
        if (vs_rise) begin
          m_mode = 0; pend_err = 1; pend_busy = 0;
        end else if (de && is_sample(x, y)) begin
          pend_wr = 1; pend_addr = m_next; pend_data = data;
          pend_sum = (pend_sum + data) % 65536;
          if (m_next == NW - 1) begin
            pend_done = 1; pend_busy = 0; m_mode = 0;
          end
          m_next++;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit vs, input bit de,
                               input int data, input int x, input int y);
    @(posedge clk);
    #1;
    rst_n = r; cap_start = s; frame_vs = vs; pix_de = de; pix_data = DW'(data);
    model_step(r, s, vs, de, data, x, y);
  endtask

  // Reset asserted while the DUT is presenting a write.
  task automatic reset_now();
    @(posedge clk);
    #1;
    checkOutput("pre_reset_wr_en", ram_wr_en, 1);
    rst_n = 0; cap_start = 0; frame_vs = 0; pix_de = 0; pix_data = '0;
    model_reset();
    #1;
    checkOutput("rst_wr_en", ram_wr_en, 0);
    checkOutput("rst_busy", cap_busy, 0);
    checkOutput("rst_done_err", {cap_done, cap_err}, 0);
    checkOutput("rst_addr_data", {ram_wr_addr, ram_wr_data}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_frame(input int nlines, input bit rnd, input int start_line,
                           input bit start_on_vs, input int rst_at);
    int hb;
    int d;
    for (int i = 0; i < 2; i++) applyStimulus(1, start_on_vs && (i == 0), 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int y = 0; y < nlines; y++) begin
      hb = $urandom_range(1, 4);
      for (int b = 0; b < hb; b++) applyStimulus(1, (y == start_line) && (b == 0), 0, 0, 0, 0, 0);
      for (int x = 0; x < FW; x++) begin
        d = rnd ? int'($urandom_range(0, 255)) : (y * 16 + x);
        applyStimulus(1, 0, 0, 1, d, x, y);
        if (rst_at >= 0 && pend_wr && pend_addr == rst_at) begin
          reset_now();
          return;
        end
      end
    end
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_logs();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic check_golden(input string tag, input int n);
    checkOutput({tag, "_writes"}, wr_cnt, n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_cnt) begin
        checkOutput({tag, "_addr"}, wr_addr_log[i], i);
        checkOutput({tag, "_data"}, wr_data_log[i], golden[i]);
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("ram_wr_en", ram_wr_en, exp_wr);
      if (exp_wr) begin
        checkOutput("ram_wr_addr", ram_wr_addr, exp_addr);
        checkOutput("ram_wr_data", ram_wr_data, exp_data);
      end
      checkOutput("cap_busy", cap_busy, exp_busy);
      checkOutput("cap_done", cap_done, exp_done);
      checkOutput("cap_err", cap_err, exp_err);
`ifdef FRUIT_TPL_CKSUM_EN
      checkOutput("tpl_cksum", tpl_cksum, exp_sum);
`endif
      if (ram_wr_en === 1'b1) begin
        wr_cnt++;
        wr_addr_log.push_back(int'(ram_wr_addr));
        wr_data_log.push_back(int'(ram_wr_data));
      end
      if (cap_done === 1'b1) done_cnt++;
      if (cap_err === 1'b1) err_cnt++;
    end
  end

  initial begin
    int kind;
    model_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    cmp_en = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_outputs", {cap_busy, cap_done, cap_err, ram_wr_en}, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    $display("[TB] basic capture");
    clear_logs();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    run_frame(8, 0, -1, 0, -1);
    check_golden("basic", 8);
    checkOutput("basic_done_cnt", done_cnt, 1);
    checkOutput("basic_err_cnt", err_cnt, 0);
`ifdef FRUIT_TPL_CKSUM_EN
    checkOutput("basic_cksum", tpl_cksum, 16'h0128);
`endif

    $display("[TB] request mid-frame");
    clear_logs();
    run_frame(8, 0, 3, 0, -1);
    checkOutput("midframe_no_writes", wr_cnt, 0);
    run_frame(8, 0, -1, 0, -1);
    check_golden("midframe", 8);
    checkOutput("midframe_done_cnt", done_cnt, 1);

    $display("[TB] short frame abort");
    clear_logs();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    run_frame(2, 0, -1, 0, -1);
    run_frame(8, 0, -1, 0, -1);
    check_golden("short", 4);
    checkOutput("short_err_cnt", err_cnt, 1);
    checkOutput("short_done_cnt", done_cnt, 0);
    checkOutput("short_busy", cap_busy, 0);

    $display("[TB] request ignored during capture");
    clear_logs();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    run_frame(8, 0, 2, 0, -1);
    run_frame(8, 0, -1, 0, -1);
    check_golden("recap", 8);
    checkOutput("recap_done_cnt", done_cnt, 1);

    $display("[TB] request coincident with frame start");
    clear_logs();
    run_frame(8, 0, -1, 1, -1);
    checkOutput("coinc_no_writes", wr_cnt, 0);
    run_frame(8, 0, -1, 0, -1);
    check_golden("coinc", 8);

    $display("[TB] reset after third write");
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    run_frame(8, 0, -1, 0, 2);
    clear_logs();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    run_frame(8, 0, -1, 0, -1);
    check_golden("after_rst", 8);
    checkOutput("after_rst_done_cnt", done_cnt, 1);

    $display("[TB] randomized captures");
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          applyStimulus(1, 1, 0, 0, 0, 0, 0);
          run_frame(8, 1, -1, 0, -1);
        end
        1: begin
          run_frame(8, 1, $urandom_range(0, 7), 0, -1);
          run_frame(8, 1, -1, 0, -1);
        end
        2: begin
          applyStimulus(1, 1, 0, 0, 0, 0, 0);
          run_frame($urandom_range(1, 4), 1, -1, 0, -1);
          run_frame(8, 1, -1, 0, -1);
        end
        default: begin
          run_frame(8, 1, -1, 1, -1);
          run_frame(8, 1, -1, 0, -1);
        end
      endcase
    end
    checkOutput("final_idle_busy", cap_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
